// File: rtl/reg_display_scheduler_pkg.sv
// Shared definitions for the register-display scheduler: FSM encodings and display geometry.
package reg_display_scheduler_pkg;

  localparam int DISP_DATA_W  = 32;
  localparam int DISP_DIGITS  = 8;
  localparam int DIGIT_W      = DISP_DATA_W / DISP_DIGITS;
  // The two leftmost digits carry the register number when address display is enabled.
  localparam int ADDR_DIGITS  = 2;
  localparam int ADDR_FIELD_W = ADDR_DIGITS * DIGIT_W;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_CAPT  = 2'd2;
  localparam logic [1:0] ST_DWELL = 2'd3;

endpackage

// File: rtl/reg_display_scheduler_dwell_timer.sv
// Dwell counter: counts while en, cleared by clr, pulses expire on the final dwell cycle.
module dwell_timer #(
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt <= '0;
    else if (clr)              cnt <= '0;
    else if (en && cnt != LAST) cnt <= cnt + 1'b1;
    else if (en)               cnt <= '0;
  end

  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/reg_display_scheduler.sv
// Reads registers over the shared debug port and holds the word for the 7-segment display.
// Build option: DISP_ADDR_EN puts the register number in the two leftmost digits.
module reg_display_scheduler
  import reg_display_scheduler_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = DISP_DATA_W,
  parameter int DWELL_CYCLES = 50_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode_auto,
  input  logic              step,
  input  logic [ADDR_W-1:0] sel_addr,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_gnt,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] seg_value,
  output logic [ADDR_W-1:0] cur_addr,
  output logic              busy
);

  logic [1:0]        state;
  logic              expire;
  logic              go;
  logic [ADDR_W-1:0] next_addr;
  logic [DATA_W-1:0] cap_word;

  dwell_timer #(.DWELL_CYCLES(DWELL_CYCLES)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (state == ST_CAPT),
    .en     (state == ST_DWELL),
    .expire (expire)
  );

  // Step and expiry together are one decision, so at most one advance/load.
  assign go = step || expire;

  always_comb begin
    next_addr = cur_addr;
    if (mode_auto)  next_addr = cur_addr + 1'b1;
    else if (step)  next_addr = sel_addr;
  end

  always_comb begin
`ifdef DISP_ADDR_EN
    cap_word = {ADDR_FIELD_W'(cur_addr), rd_data[DATA_W-ADDR_FIELD_W-1:0]};
`else
    cap_word = rd_data;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      seg_value <= '0;
      cur_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          state    <= ST_REQ;
          cur_addr <= '0;
          rd_addr  <= '0;
          rd_req   <= 1'b1;
          busy     <= 1'b1;
        end
        ST_REQ: begin
          if (rd_gnt) begin
            state  <= ST_CAPT;
            rd_req <= 1'b0;
          end
        end
        ST_CAPT: begin
          seg_value <= cap_word;
          busy      <= 1'b0;
          state     <= ST_DWELL;
        end
        default: begin
          if (go) begin
            cur_addr <= next_addr;
            rd_addr  <= next_addr;
            rd_req   <= 1'b1;
            busy     <= 1'b1;
            state    <= ST_REQ;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_display_scheduler.sv
// Directed bench for reg_display_scheduler with an 8-cycle dwell.
module tb_reg_display_scheduler;

  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          mode_auto = 1'b1;
  logic          step = 1'b0;
  logic [AW-1:0] sel_addr = '0;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt = 1'b0;
  logic [DW-1:0] rd_data = '0;
  logic [DW-1:0] seg_value;
  logic [AW-1:0] cur_addr;
  logic          busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reg_display_scheduler #(.ADDR_W(AW), .DATA_W(DW), .DWELL_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .mode_auto(mode_auto), .step(step), .sel_addr(sel_addr),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_data(rd_data),
    .seg_value(seg_value), .cur_addr(cur_addr), .busy(busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_seg(input logic [AW-1:0] a, input logic [31:0] d);
`ifdef DISP_ADDR_EN
    logic [7:0] a8;
    a8 = 8'(a);
    return {a8, d[23:0]};
`else
    return d;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic pulse_step();
    step = 1'b1;
    tick();
    step = 1'b0;
  endtask

  // Grant the pending request and return data one cycle later; ends on the capture edge.
  task automatic serve(input logic [31:0] d);
    int n;
    n = 0;
    while (!rd_req && n < 20) begin
      tick();
      n++;
    end
    if (!rd_req) chk("serve_timeout", 32'(rd_req), 32'd1);
    rd_gnt = 1'b1;
    tick();
    rd_gnt  = 1'b0;
    rd_data = d;
    tick();
  endtask

  initial begin
    int guard;

    // 1. reset
    ticks(3);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_seg", seg_value, 0);
    chk("rst_cur_addr", 32'(cur_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1'b0;
    ticks(2);
    chk("rel_rd_req", 32'(rd_req), 1);
    chk("rel_rd_addr", 32'(rd_addr), 0);
    chk("rel_busy", 32'(busy), 1);

    // 2. grant wait, then capture at grant+2
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("wait_rd_req", 32'(rd_req), 1);
      chk("wait_rd_addr", 32'(rd_addr), 0);
    end
    rd_gnt = 1'b1;
    tick();
    rd_gnt  = 1'b0;
    rd_data = 32'hDEADBEEF;
    chk("gnt1_rd_req", 32'(rd_req), 0);
    chk("gnt1_seg_hold", seg_value, 0);
    chk("gnt1_busy", 32'(busy), 1);
    tick();
    chk("gnt2_seg", seg_value, exp_seg(5'd0, 32'hDEADBEEF));
    chk("gnt2_busy", 32'(busy), 0);

    // auto dwell expiry after 8 cycles
    ticks(7);
    chk("dwell7_rd_req", 32'(rd_req), 0);
    tick();
    chk("dwell8_rd_req", 32'(rd_req), 1);
    chk("dwell8_rd_addr", 32'(rd_addr), 1);
    chk("dwell8_cur_addr", 32'(cur_addr), 1);

    // step coinciding with expiry advances once
    serve(32'h0000_1111);
    ticks(7);
    pulse_step();
    chk("step_exp_rd_addr", 32'(rd_addr), 2);
    chk("step_exp_rd_req", 32'(rd_req), 1);

    // 3. walk up to R31 with steps, then wrap on expiry
    guard = 0;
    while (cur_addr != 5'd31 && guard < 40) begin
      serve(32'(cur_addr) * 32'h0101_0101);
      pulse_step();
      guard++;
    end
    chk("reach_31", 32'(cur_addr), 31);
    serve(32'h1234_5678);
    chk("seg_r31", seg_value, exp_seg(5'd31, 32'h1234_5678));
    ticks(8);
    chk("wrap_rd_req", 32'(rd_req), 1);
    chk("wrap_rd_addr", 32'(rd_addr), 0);
    serve(32'hA5A5_0000);
    ticks(3);
    pulse_step();
    chk("mid_step_rd_req", 32'(rd_req), 1);
    chk("mid_step_rd_addr", 32'(rd_addr), 1);

    // 4. manual select, step in REQ ignored, refresh on expiry
    mode_auto = 1'b0;
    serve(32'h0BAD_F00D);
    sel_addr = 5'd5;
    pulse_step();
    chk("man_rd_req", 32'(rd_req), 1);
    chk("man_rd_addr", 32'(rd_addr), 5);
    sel_addr = 5'd9;
    pulse_step();
    chk("req_step_rd_addr", 32'(rd_addr), 5);
    chk("req_step_cur", 32'(cur_addr), 5);
    serve(32'h0000_0055);
    chk("man_seg", seg_value, exp_seg(5'd5, 32'h0000_0055));
    ticks(7);
    chk("refresh7_rd_req", 32'(rd_req), 0);
    tick();
    chk("refresh_rd_req", 32'(rd_req), 1);
    chk("refresh_rd_addr", 32'(rd_addr), 5);

    // 5. async reset mid-REQ, late grant ignored
    reset = 1'b1;
    #1;
    chk("areset_rd_req", 32'(rd_req), 0);
    chk("areset_seg", seg_value, 0);
    ticks(2);
    rd_data = 32'hFFFF_FFFF;
    reset   = 1'b0;
    rd_gnt  = 1'b1;
    tick();
    rd_gnt = 1'b0;
    ticks(3);
    chk("late_gnt_seg", seg_value, 0);
    chk("late_gnt_rd_req", 32'(rd_req), 1);
    chk("late_gnt_busy", 32'(busy), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
